// File: rtl/n64_pi_pkg.sv
// rtl/n64_pi_pkg.sv - shared types and constants for the N64 PI cartridge slave
package n64_pi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_ACTIVE = 2'd2
  } pi_state_t;

  localparam logic [31:0] PI_ADDR_BASE_DEF = 32'h1000_0000;
  localparam logic [31:0] PI_ADDR_MASK_DEF = 32'hFC00_0000;
  localparam logic [15:0] PI_UNDERRUN_FILL = 16'hFFFF;

  // Error counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/n64_pi_sync.sv
// rtl/n64_pi_sync.sv - multi-flop strobe synchroniser with rise/fall pulses
module n64_pi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] pipe;
  logic              last_d;

  // Shift the async strobe through the chain and keep a delayed copy of the last stage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pipe   <= {STAGES{RESET_VAL}};
      last_d <= RESET_VAL;
    end else begin
      pipe   <= {pipe[STAGES-2:0], d};
      last_d <= pipe[STAGES-1];
    end
  end

  assign rise = pipe[STAGES-1] & ~last_d;
  assign fall = ~pipe[STAGES-1] & last_d;

endmodule

// File: rtl/n64_pi_cart_slave.sv
// rtl/n64_pi_cart_slave.sv - N64 PI cartridge-bus slave with read prefetch and posted writes
module n64_pi_cart_slave
  import n64_pi_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE      = PI_ADDR_BASE_DEF,
  parameter logic [31:0] ADDR_MASK      = PI_ADDR_MASK_DEF,
  parameter int          MEM_AW         = 24,
  parameter int          SYNC_STAGES    = 2,
  parameter int          PREFETCH_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [15:0]       N64_AD_in,
  output logic [15:0]       N64_AD_out,
  output logic              N64_AD_oe,
  input  logic              N64_ALE_H,
  input  logic              N64_ALE_L,
  input  logic              N64_READ_N,
  input  logic              N64_WRITE_N,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [7:0]        underrun_cnt,
  output logic [7:0]        overrun_cnt
);

  localparam int                PTR_W     = $clog2(PREFETCH_DEPTH);
  localparam logic [PTR_W:0]    DEPTH_CNT = (PTR_W+1)'(PREFETCH_DEPTH);
  localparam logic [MEM_AW-1:0] BASE_IDX  = ADDR_BASE[MEM_AW:1];

  // Strobe edges, all aligned to the last synchroniser stage.
  logic ale_h_rise, ale_h_fall, ale_l_rise, ale_l_fall;
  logic read_rise, read_fall, write_rise, write_fall;

  n64_pi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_ale_h (
    .clk(clk), .resetn(resetn), .d(N64_ALE_H), .rise(ale_h_rise), .fall(ale_h_fall));
  n64_pi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_ale_l (
    .clk(clk), .resetn(resetn), .d(N64_ALE_L), .rise(ale_l_rise), .fall(ale_l_fall));
  n64_pi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_read (
    .clk(clk), .resetn(resetn), .d(N64_READ_N), .rise(read_rise), .fall(read_fall));
  n64_pi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_write (
    .clk(clk), .resetn(resetn), .d(N64_WRITE_N), .rise(write_rise), .fall(write_fall));

  // AD goes through the same depth so it lines up with the strobe edges.
  logic [15:0] ad_pipe [SYNC_STAGES];
  logic [15:0] ad_sync;

  // Delay line for the multiplexed AD bus.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) ad_pipe[i] <= '0;
    end else begin
      ad_pipe[0] <= N64_AD_in;
      for (int i = 1; i < SYNC_STAGES; i++) ad_pipe[i] <= ad_pipe[i-1];
    end
  end

  assign ad_sync = ad_pipe[SYNC_STAGES-1];

  pi_state_t         state, state_next;
  logic              active, rd_go, wr_go, flush;
  logic [31:0]       bus_addr, bus_next, ale_addr;
  logic              ale_hit;
  logic [MEM_AW-1:0] ale_idx, bus_idx, bus_next_idx, fetch_idx;

  logic [15:0]       fifo_mem [PREFETCH_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    fifo_count;
  logic              fifo_empty, push, pop;
  logic              epoch, req_epoch;

  logic              wbuf_valid;
  logic [MEM_AW-1:0] wbuf_idx;
  logic [15:0]       wbuf_data;
  logic              wr_ack;

  assign ale_addr     = {bus_addr[31:16], ad_sync[15:1], 1'b0};
  assign ale_hit      = ((ale_addr & ADDR_MASK) == ADDR_BASE);
  assign bus_next     = bus_addr + 32'd2;
  assign ale_idx      = ale_addr[MEM_AW:1] - BASE_IDX;
  assign bus_idx      = bus_addr[MEM_AW:1] - BASE_IDX;
  assign bus_next_idx = bus_next[MEM_AW:1] - BASE_IDX;

  assign flush      = ale_l_fall | wr_go;
  assign fifo_empty = (fifo_count == '0);
  // Stale acks (epoch changed since issue) are dropped on the floor.
  assign push       = mem_req & mem_ack & ~mem_we & (req_epoch == epoch) & ~flush;
  assign pop        = rd_go & ~fifo_empty & ~flush;
  assign wr_ack     = mem_req & mem_ack & mem_we;

  logic unused_sigs;
  assign unused_sigs = &{1'b0, ale_h_rise, write_fall, bus_next[31:MEM_AW+1], bus_next[0]};

  // Bus-phase state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Address phase opens on ALE_L rise and resolves to a hit or miss on ALE_L fall.
  always_comb begin
    state_next = state;
    if (ale_l_rise)                            state_next = ST_ADDR;
    else if (ale_l_fall && state == ST_ADDR)   state_next = ale_hit ? ST_ACTIVE : ST_IDLE;
  end

  // Bus strobes only act while the window is selected.
  always_comb begin
    active = 1'b0;
    rd_go  = 1'b0;
    wr_go  = 1'b0;
    if (state == ST_ACTIVE) begin
      active = 1'b1;
      rd_go  = read_fall;
      wr_go  = write_rise;
    end
  end

  // Bus address, AD drive, write buffer and error counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_addr     <= '0;
      N64_AD_out   <= '0;
      N64_AD_oe    <= 1'b0;
      underrun_cnt <= '0;
      overrun_cnt  <= '0;
      wbuf_valid   <= 1'b0;
      wbuf_idx     <= '0;
      wbuf_data    <= '0;
    end else begin
      if (ale_l_rise)              bus_addr <= '0;
      else if (ale_h_fall)         bus_addr[31:16] <= ad_sync;
      else if (ale_l_fall)         bus_addr <= ale_addr;
      else if (rd_go || wr_go)     bus_addr <= bus_next;

      if (ale_l_rise || ale_l_fall || read_rise) N64_AD_oe <= 1'b0;
      else if (rd_go)                            N64_AD_oe <= 1'b1;

      if (rd_go) begin
        if (fifo_empty) begin
          N64_AD_out   <= PI_UNDERRUN_FILL;
          underrun_cnt <= sat_inc8(underrun_cnt);
        end else begin
          N64_AD_out   <= fifo_mem[rd_ptr];
        end
      end

      if (wr_go && !wbuf_valid) begin
        wbuf_valid <= 1'b1;
        wbuf_idx   <= bus_idx;
        wbuf_data  <= ad_sync;
      end else if (wr_ack) begin
        wbuf_valid <= 1'b0;
      end
      if (wr_go && wbuf_valid) overrun_cnt <= sat_inc8(overrun_cnt);
    end
  end

  // Prefetch FIFO pointers, fetch address and flush epoch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fetch_idx  <= '0;
      epoch      <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      epoch      <= ~epoch;
      fetch_idx  <= ale_l_fall ? ale_idx : bus_next_idx;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + PTR_W'(1);
        fetch_idx <= fetch_idx + MEM_AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Prefetch data storage.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rdata;
  end

  // Backing-memory request: held until ack, posted write wins over prefetch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      req_epoch <= 1'b0;
    end else if (mem_req) begin
      if (mem_ack) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
    end else if (wbuf_valid) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b1;
      mem_addr  <= wbuf_idx;
      mem_wdata <= wbuf_data;
    end else if (active && !flush && fifo_count < DEPTH_CNT) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= fetch_idx;
      req_epoch <= epoch;
    end
  end

endmodule

// File: tb/tb_n64_pi_cart_slave.sv
// tb/tb_n64_pi_cart_slave.sv - scoreboard bench for the N64 PI cartridge slave
module tb_n64_pi_cart_slave;

  logic        clk;
  logic        resetn;
  logic [15:0] N64_AD_in;
  logic [15:0] N64_AD_out;
  logic        N64_AD_oe;
  logic        N64_ALE_H, N64_ALE_L, N64_READ_N, N64_WRITE_N;
  logic        mem_req, mem_we, mem_ack;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [7:0]  underrun_cnt, overrun_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] exp_rd[$];
  int          exp_wa[$];
  logic [15:0] exp_wd[$];

  logic [15:0] wmem [int];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic        oe_q = 1'b0;
  logic        wr_seen = 1'b0;

  n64_pi_cart_slave dut (
    .clk(clk), .resetn(resetn),
    .N64_AD_in(N64_AD_in), .N64_AD_out(N64_AD_out), .N64_AD_oe(N64_AD_oe),
    .N64_ALE_H(N64_ALE_H), .N64_ALE_L(N64_ALE_L),
    .N64_READ_N(N64_READ_N), .N64_WRITE_N(N64_WRITE_N),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .underrun_cnt(underrun_cnt), .overrun_cnt(overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Backing memory: unwritten halfwords read back as their own index.
  always @(negedge clk) begin
    if (!resetn) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_req && !mem_ack) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        if (mem_we) wmem[int'(mem_addr)] = mem_wdata;
        else begin
          int a;
          a = int'(mem_addr);
          mem_rdata = wmem.exists(a) ? wmem[a] : a[15:0];
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      mem_ack = 1'b0;
    end
  end

  // Monitor: compare each read drive and each new write request against the queues.
  always @(negedge clk) begin
    if (N64_AD_oe && !oe_q) begin
      if (exp_rd.size() == 0) begin
        tests_run++; tests_failed++;
        $display("FAIL unexpected_read: got %h expected no drive", N64_AD_out);
      end else begin
        check("rd_data", N64_AD_out, exp_rd.pop_front());
      end
    end
    oe_q = N64_AD_oe;
    if (mem_req && mem_we && !wr_seen) begin
      wr_seen = 1'b1;
      if (exp_wa.size() == 0) begin
        tests_run++; tests_failed++;
        $display("FAIL unexpected_write: got addr %h data %h expected none", mem_addr, mem_wdata);
      end else begin
        check("wr_addr", mem_addr, exp_wa.pop_front());
        check("wr_data", mem_wdata, exp_wd.pop_front());
      end
    end
    if (!mem_req) wr_seen = 1'b0;
  end

  task automatic do_reset();
    resetn = 1'b0;
    mem_ack = 1'b0;
    cyc(2);
    resetn = 1'b1;
    cyc(2);
  endtask

  task automatic ale_seq(input logic [31:0] a);
    N64_ALE_H = 1'b1; cyc(2);
    N64_ALE_L = 1'b1; cyc(4);
    N64_AD_in = a[31:16]; cyc(2);
    N64_ALE_H = 1'b0; cyc(4);
    N64_AD_in = a[15:0]; cyc(2);
    N64_ALE_L = 1'b0; cyc(6);
  endtask

  task automatic do_read(output logic oe_seen, output logic req_seen);
    oe_seen = 1'b0;
    req_seen = 1'b0;
    check("oe_before_read", N64_AD_oe, 1'b0);
    N64_READ_N = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      oe_seen |= N64_AD_oe;
      req_seen |= mem_req;
    end
    N64_READ_N = 1'b1;
    cyc(5);
    check("oe_after_read", N64_AD_oe, 1'b0);
  endtask

  task automatic do_write(input logic [15:0] d);
    N64_AD_in = d;
    N64_WRITE_N = 1'b0; cyc(4);
    N64_WRITE_N = 1'b1; cyc(8);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic oe_s, req_s;
    resetn = 1'b0;
    N64_AD_in = '0; N64_ALE_H = 1'b0; N64_ALE_L = 1'b0;
    N64_READ_N = 1'b1; N64_WRITE_N = 1'b1;
    mem_ack = 1'b0; mem_rdata = '0;
    cyc(2);
    check("rst_oe", N64_AD_oe, 1'b0);
    check("rst_ad_out", N64_AD_out, 16'h0000);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 24'h0);
    check("rst_mem_wdata", mem_wdata, 16'h0);
    check("rst_underrun", underrun_cnt, 8'h0);
    check("rst_overrun", overrun_cnt, 8'h0);
    resetn = 1'b1;
    cyc(2);

    // Sequential prefetched reads from 0x1000_0040 (halfword index 0x20).
    ack_delay = 0;
    ale_seq(32'h1000_0040);
    for (int i = 0; i < 4; i++) begin
      exp_rd.push_back(16'h0020 + 16'(i));
      do_read(oe_s, req_s);
      check("oe_during_read", oe_s, 1'b1);
    end
    check("underrun_none", underrun_cnt, 8'h0);

    // Address outside the window: no drive, no memory traffic.
    do_reset();
    ale_seq(32'h0800_0000);
    do_read(oe_s, req_s);
    check("miss_oe", oe_s, 1'b0);
    check("miss_req", req_s, 1'b0);

    // Slow memory: read before any data arrives returns fill and counts underrun.
    do_reset();
    ack_delay = 20;
    ale_seq(32'h1000_0040);
    exp_rd.push_back(16'hFFFF);
    do_read(oe_s, req_s);
    check("underrun_cnt", underrun_cnt, 8'h1);
    ack_delay = 0;
    cyc(30);

    // Two posted writes, then reads continue after the written range.
    do_reset();
    ale_seq(32'h1000_0000);
    exp_wa.push_back(0); exp_wd.push_back(16'hBEEF);
    do_write(16'hBEEF);
    exp_wa.push_back(1); exp_wd.push_back(16'hCAFE);
    do_write(16'hCAFE);
    exp_rd.push_back(16'h0002);
    do_read(oe_s, req_s);
    exp_rd.push_back(16'h0003);
    do_read(oe_s, req_s);
    check("wr_overrun_none", overrun_cnt, 8'h0);

    // Write buffer stuck behind an unacked request: second write dropped.
    do_reset();
    ack_delay = 1000;
    ale_seq(32'h1000_0000);
    exp_wa.push_back(0); exp_wd.push_back(16'h1111);
    do_write(16'h1111);
    do_write(16'h2222);
    check("overrun_cnt", overrun_cnt, 8'h1);
    ack_delay = 0;
    cyc(30);

    // Asynchronous reset mid-read with a request outstanding.
    do_reset();
    ack_delay = 1000;
    ale_seq(32'h1000_0040);
    exp_rd.push_back(16'hFFFF);
    N64_READ_N = 1'b0;
    cyc(4);
    check("pre_rst_oe", N64_AD_oe, 1'b1);
    check("pre_rst_req", mem_req, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_oe", N64_AD_oe, 1'b0);
    check("async_rst_req", mem_req, 1'b0);
    cyc(2);
    N64_READ_N = 1'b1;
    resetn = 1'b1;
    ack_delay = 0;
    cyc(4);
    do_read(oe_s, req_s);
    check("post_rst_idle_oe", oe_s, 1'b0);
    check("post_rst_idle_req", req_s, 1'b0);

    cyc(10);
    check("rd_queue_empty", exp_rd.size(), 0);
    check("wr_queue_empty", exp_wa.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
